// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg                                                                  |
// | Shared FSM encoding, accumulator sizing and result mapping for conv IP.   |
// | Result mapping honours CONV_SATURATE_EN (saturate) or wraps modulo.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package conv_pkg;

    typedef logic [2:0] conv_state_t;

    localparam conv_state_t ST_IDLE  = 3'd0;
    localparam conv_state_t ST_SETUP = 3'd1;
    localparam conv_state_t ST_READ  = 3'd2;
    localparam conv_state_t ST_DRAIN = 3'd3;
    localparam conv_state_t ST_WRITE = 3'd4;
    localparam conv_state_t ST_DONE  = 3'd5;

    // Wide enough to hold 2**aw full-scale products without overflow.
    function automatic int unsigned conv_acc_width(input int unsigned dw,
                                                   input int unsigned aw);
        return 2 * dw + aw + 1;
    endfunction

    // Maps an accumulator (zero-extended to 64 bits) onto a zw-bit word, zw < 64.
    function automatic logic [63:0] conv_map_result(input logic [63:0] acc,
                                                    input int unsigned zw);
        logic [63:0] mask;
        mask = (64'd1 << zw) - 64'd1;
`ifdef CONV_SATURATE_EN
        if ((acc & ~mask) != 64'd0) begin
            return mask;
        end
        return acc;
`else
        return acc & mask;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_engine_if                                                            |
// | Operand read ports (memX/memY) and result write port (memZ) bundle.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface conv_engine_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned ZDATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  memX_addr;
    logic [DATA_WIDTH-1:0]  memX_data;
    logic [ADDR_WIDTH-1:0]  memY_addr;
    logic [DATA_WIDTH-1:0]  memY_data;
    logic                   memZ_we;
    logic [ADDR_WIDTH:0]    memZ_addr;
    logic [ZDATA_WIDTH-1:0] memZ_data;

    modport master (
        output memX_addr, memY_addr, memZ_we, memZ_addr, memZ_data,
        input  memX_data, memY_data
    );

    modport slave (
        input  memX_addr, memY_addr, memZ_we, memZ_addr, memZ_data,
        output memX_data, memY_data
    );
endinterface
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mac                                                                  |
// | Registered unsigned multiply-accumulate with synchronous clear/enable.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module conv_mac #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 22
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clr_i,
    input  wire logic                  en_i,
    input  wire logic [DATA_WIDTH-1:0] a_i,
    input  wire logic [DATA_WIDTH-1:0] b_i,
    output logic      [ACC_WIDTH-1:0]  acc_o
);
    logic [2*DATA_WIDTH-1:0] prod_w;
    logic [ACC_WIDTH-1:0]    acc_q;

    assign prod_w = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    assign acc_o  = acc_q;

    // Clear wins over enable so a new output index always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_WIDTH'(prod_w);
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_engine                                                               |
// | Sequences memX/memY reads, MACs and memZ writes for Z = X (*) Y.          |
// | Result width mapping selected by CONV_SATURATE_EN (see conv_pkg).         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module conv_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned ZDATA_WIDTH = 16
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start_i,
    input  wire logic [ADDR_WIDTH:0] sizeX_i,
    input  wire logic [ADDR_WIDTH:0] sizeY_i,
    conv_engine_if.master            mem,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int unsigned ACC_WIDTH = conv_acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_LEN = CW'(2 ** ADDR_WIDTH);

    conv_state_t state_q, state_d;
    logic [CW-1:0] n_q, n_d, m_q, m_d, i_q, i_d, j_q, j_d, jhi_q, jhi_d;
    logic          vld_q;
    logic [ADDR_WIDTH-1:0]  xaddr_q, yaddr_q;
    logic [CW-1:0]          zaddr_q;
    logic [ZDATA_WIDTH-1:0] zdata_q;

    logic [CW-1:0]          sx_w, sy_w, ip1_w, jlo_w, jhi_w;
    logic                   last_w;
    logic [ADDR_WIDTH-1:0]  xaddr_w, yaddr_w;
    logic [ACC_WIDTH-1:0]   acc_w;
    logic [ZDATA_WIDTH-1:0] zres_w;

    assign sx_w  = (sizeX_i > MAX_LEN) ? MAX_LEN : sizeX_i;
    assign sy_w  = (sizeY_i > MAX_LEN) ? MAX_LEN : sizeY_i;

    // Window of valid j for output i: max(0, i-N+1) .. min(i, M-1).
    assign ip1_w = i_q + CW'(1);
    assign jlo_w = (ip1_w > n_q) ? (ip1_w - n_q) : '0;
    assign jhi_w = (i_q < m_q) ? i_q : (m_q - CW'(1));
    assign last_w = ({1'b0, i_q} + (CW+1)'(2)) == ({1'b0, n_q} + {1'b0, m_q});

    assign xaddr_w = ADDR_WIDTH'(i_q - j_q);
    assign yaddr_w = ADDR_WIDTH'(j_q);
    assign zres_w  = ZDATA_WIDTH'(conv_map_result(64'(acc_w), ZDATA_WIDTH));

    conv_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_SETUP),
        .en_i  (vld_q),
        .a_i   (mem.memX_data),
        .b_i   (mem.memY_data),
        .acc_o (acc_w)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        i_d     = i_q;
        j_d     = j_q;
        jhi_d   = jhi_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = sx_w;
                    m_d     = sy_w;
                    i_d     = '0;
                    state_d = (sx_w == '0 || sy_w == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                j_d     = jlo_w;
                jhi_d   = jhi_w;
                state_d = ST_READ;
            end
            ST_READ: begin
                j_d = j_q + CW'(1);
                if (j_q == jhi_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (last_w) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + CW'(1);
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            jhi_q   <= '0;
            vld_q   <= 1'b0;
            xaddr_q <= '0;
            yaddr_q <= '0;
            zaddr_q <= '0;
            zdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            i_q     <= i_d;
            j_q     <= j_d;
            jhi_q   <= jhi_d;
            vld_q   <= (state_q == ST_READ);
            if (state_q == ST_READ) begin
                xaddr_q <= xaddr_w;
                yaddr_q <= yaddr_w;
            end
            if (state_q == ST_WRITE) begin
                zaddr_q <= i_q;
                zdata_q <= zres_w;
            end
        end
    end

    // Ports follow the live value in READ/WRITE and hold the last one elsewhere.
    assign mem.memX_addr = (state_q == ST_READ)  ? xaddr_w : xaddr_q;
    assign mem.memY_addr = (state_q == ST_READ)  ? yaddr_w : yaddr_q;
    assign mem.memZ_we   = (state_q == ST_WRITE);
    assign mem.memZ_addr = (state_q == ST_WRITE) ? i_q    : zaddr_q;
    assign mem.memZ_data = (state_q == ST_WRITE) ? zres_w : zdata_q;

    assign busy_o = (state_q == ST_IDLE && start_i) ||
                    (state_q != ST_IDLE && state_q != ST_DONE);
    assign done_o = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_conv_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_engine                                                            |
// | Directed self-checking bench for conv_engine (CONV_SATURATE_EN aware).    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_conv_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [5:0] sizeX = '0, sizeY = '0, sizeX2 = '0, sizeY2 = '0;
    logic       busy, done, busy2, done2;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    conv_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ZDATA_WIDTH(16)) ifc ();
    conv_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ZDATA_WIDTH(8))  ifc2 ();

    conv_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ZDATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .sizeX_i(sizeX), .sizeY_i(sizeY),
        .mem(ifc.master), .busy_o(busy), .done_o(done)
    );

    conv_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ZDATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .sizeX_i(sizeX2), .sizeY_i(sizeY2),
        .mem(ifc2.master), .busy_o(busy2), .done_o(done2)
    );

    // Operand memories with one-cycle read latency, and memZ write logs.
    logic [7:0]  mx [32], my [32], mx2 [32], my2 [32];
    int          wa [$], wa2 [$];
    logic [15:0] wd [$];
    logic [7:0]  wd2 [$];

    always @(posedge clk) begin
        ifc.memX_data  <= mx[ifc.memX_addr];
        ifc.memY_data  <= my[ifc.memY_addr];
        ifc2.memX_data <= mx2[ifc2.memX_addr];
        ifc2.memY_data <= my2[ifc2.memY_addr];
        if (ifc.memZ_we === 1'b1) begin
            wa.push_back(int'(ifc.memZ_addr));
            wd.push_back(ifc.memZ_data);
        end
        if (ifc2.memZ_we === 1'b1) begin
            wa2.push_back(int'(ifc2.memZ_addr));
            wd2.push_back(ifc2.memZ_data);
        end
    end

`ifdef CONV_SATURATE_EN
    localparam logic [7:0] EXP_Z8 = 8'hFF;
`else
    localparam logic [7:0] EXP_Z8 = 8'h00;
`endif

    // Runs one job on the 16-bit DUT; lat is edges from start edge to done seen.
    task automatic run_job(input logic [5:0] n, input logic [5:0] m, input bit inject,
                           output int lat, output int bcnt);
        wa.delete();
        wd.delete();
        @(negedge clk);
        sizeX = n;
        sizeY = m;
        start = 1'b1;
        #1 bcnt = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 5000) begin
            if (busy === 1'b1) bcnt++;
            if (inject && lat == 6) begin
                start = 1'b1;
                sizeX = 6'd1;
                sizeY = 6'd1;
            end else if (inject && lat == 7) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_results(input string name, input logic [15:0] exp[], input int lat,
                                 input int exp_lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        vectors++;
        if (wa.size() !== exp.size()) begin
            miscompares++;
            $display("FAIL %s write count: got %0d expected %0d", name, wa.size(), exp.size());
        end
        for (int k = 0; k < exp.size(); k++) begin
            int          ga;
            logic [15:0] gd;
            ga = (k < wa.size()) ? wa[k] : -1;
            gd = (k < wd.size()) ? wd[k] : 16'hxxxx;
            vectors++;
            if (ga !== k || gd !== exp[k]) begin
                miscompares++;
                $display("FAIL %s z[%0d]: got addr %0d data %h expected addr %0d data %h",
                         name, k, ga, gd, k, exp[k]);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy at done: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, ifc.memZ_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset flags: got busy/done/we %b expected 000", {busy, done, ifc.memZ_we});
        end
        vectors++;
        if ({ifc.memX_addr, ifc.memY_addr} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset rd addr: got %h/%h expected 0/0", ifc.memX_addr, ifc.memY_addr);
        end
        vectors++;
        if ({ifc.memZ_addr, ifc.memZ_data} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset wr port: got %h/%h expected 0/0", ifc.memZ_addr, ifc.memZ_data);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        mx[0] = 8'd1; mx[1] = 8'd2; mx[2] = 8'd3;
        my[0] = 8'd4; my[1] = 8'd5;
        run_job(6'd3, 6'd2, 1'b0, lat, bcnt);
        check_results("basic3x2", '{16'd4, 16'd13, 16'd22, 16'd15}, lat, 19);
    endtask

    task automatic test_single_max();
        int lat, bcnt;
        mx[0] = 8'hFF;
        my[0] = 8'hFF;
        run_job(6'd1, 6'd1, 1'b0, lat, bcnt);
        check_results("single_ff", '{16'hFE01}, lat, 5);
    endtask

    task automatic test_empty();
        int lat, bcnt;
        run_job(6'd0, 6'd4, 1'b0, lat, bcnt);
        check_results("empty", '{}, lat, 1);
        vectors++;
        if (bcnt !== 1) begin
            miscompares++;
            $display("FAIL empty busy cycles: got %0d expected 1", bcnt);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bcnt;
        mx[0] = 8'd1; mx[1] = 8'd2; mx[2] = 8'd3;
        my[0] = 8'd4; my[1] = 8'd5;
        run_job(6'd3, 6'd2, 1'b1, lat, bcnt);
        check_results("ignore_start", '{16'd4, 16'd13, 16'd22, 16'd15}, lat, 19);
    endtask

    task automatic test_zwidth8();
        int lat;
        mx2[0] = 8'h10; mx2[1] = 8'h20;
        my2[0] = 8'h10;
        wa2.delete();
        wd2.delete();
        @(negedge clk);
        sizeX2 = 6'd2;
        sizeY2 = 6'd1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL zw8 latency: got %0d expected 9", lat);
        end
        vectors++;
        if (wa2.size() !== 2 || wd2.size() !== 2) begin
            miscompares++;
            $display("FAIL zw8 write count: got %0d expected 2", wa2.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (wa2[k] !== k || wd2[k] !== EXP_Z8) begin
                    miscompares++;
                    $display("FAIL zw8 z[%0d]: got addr %0d data %h expected addr %0d data %h",
                             k, wa2[k], wd2[k], k, EXP_Z8);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        bit found;
        for (int k = 0; k < 4; k++) begin
            mx[k] = 8'(k + 1);
            my[k] = 8'd1;
        end
        wa.delete();
        wd.delete();
        @(negedge clk);
        sizeX = 6'd4;
        sizeY = 6'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (ifc.memZ_we === 1'b1 && ifc.memZ_addr === 6'd2) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rst_mid wait: got no write of index 2 expected one within 500 cycles");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ifc.memZ_we, busy, done} !== 3'b000 || ifc.memZ_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL rst_mid outputs: got we/busy/done %b zaddr %0d expected 000 zaddr 0",
                     {ifc.memZ_we, busy, done}, ifc.memZ_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (wa.size() !== 2) begin
            miscompares++;
            $display("FAIL rst_mid writes before abort: got %0d expected 2", wa.size());
        end
        run_job(6'd4, 6'd4, 1'b0, lat, bcnt);
        check_results("rst_mid_rerun",
                      '{16'd1, 16'd3, 16'd6, 16'd10, 16'd9, 16'd7, 16'd4}, lat, 38);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            mx[k] = '0; my[k] = '0; mx2[k] = '0; my2[k] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_single_max();
        test_empty();
        test_ignore_start();
        test_zwidth8();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
